// File: rtl/mem_map_pkg.sv
// Shared address map for the data-side memory responder: register offsets,
// default register-page base, and the address-select encoding.
package mem_map_pkg;

    localparam logic [31:0] LED_OFS         = 32'h0000_0000;
    localparam logic [31:0] TCOUNT_OFS      = 32'h0000_0004;
    localparam logic [31:0] TCMP_OFS        = 32'h0000_0008;
    localparam logic [31:0] TSTAT_OFS       = 32'h0000_000C;
    localparam logic [31:0] DEFAULT_IO_BASE = 32'h0000_1000;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_TCOUNT,
        SEL_TCMP,
        SEL_TSTAT,
        SEL_NONE
    } sel_e;

    // Word number of a register, so decode can ignore the byte-lane bits.
    function automatic logic [29:0] reg_word(input logic [31:0] base, input logic [31:0] ofs);
        logic [31:0] full;
        full = base + ofs;
        return full[31:2];
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Interval timer for the register page: free-running counter, compare
// register, and a sticky match flag with write-over-increment priority.
module mmio_timer
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  sel_e        sel,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic        flag
);

    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        flag_q, flag_d;
    logic        match;

    // A match sets the flag even when software clears it on the same edge.
    always_comb begin
        count_d = count_q + 32'd1;
        cmp_d   = cmp_q;
        flag_d  = flag_q;
        match   = (count_q == cmp_q) && (cmp_q != 32'd0);

        if (wr_en && sel == SEL_TCOUNT) begin
            count_d = wdata;
        end
        if (wr_en && sel == SEL_TCMP) begin
            cmp_d = wdata;
        end
        if (wr_en && sel == SEL_TSTAT && wdata[0]) begin
            flag_d = 1'b0;
        end
        if (match) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
            cmp_q   <= 32'd0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            flag_q  <= flag_d;
        end
    end

    assign count = count_q;
    assign cmp   = cmp_q;
    assign flag  = flag_q;

endmodule

// File: rtl/data_mem_bus.sv
// Data-side memory responder: word RAM plus LED latch and, when TIMER_EN is
// defined, an interval timer. Reads are combinational, writes commit on CLK.
module data_mem_bus
    import mem_map_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] IO_BASE     = DEFAULT_IO_BASE
)
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        irq
);

    localparam int          ADDR_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES   = 32'(DEPTH_WORDS * 4);
    localparam logic [29:0] LED_WORD    = reg_word(IO_BASE, LED_OFS);
`ifdef TIMER_EN
    localparam logic [29:0] TCOUNT_WORD = reg_word(IO_BASE, TCOUNT_OFS);
    localparam logic [29:0] TCMP_WORD   = reg_word(IO_BASE, TCMP_OFS);
    localparam logic [29:0] TSTAT_WORD  = reg_word(IO_BASE, TSTAT_OFS);
`endif

    logic [1:0]        rst_sync_q, rst_sync_d;
    logic              rst_n_int;
    logic              wr_en;
    sel_e              sel;
    logic [29:0]       word_addr;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_q [DEPTH_WORDS];
    logic [7:0]        leds_q, leds_d;

    // Reset asserts asynchronously but releases only after two clean edges.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q[1];
    assign wr_en     = MemWrite & rst_n_int;
    assign word_addr = ALUResult[31:2];
    assign ram_idx   = ALUResult[2 +: ADDR_W];

    always_comb begin
        sel = SEL_NONE;
        if (ALUResult < RAM_BYTES) begin
            sel = SEL_RAM;
        end else if (word_addr == LED_WORD) begin
            sel = SEL_LED;
`ifdef TIMER_EN
        end else if (word_addr == TCOUNT_WORD) begin
            sel = SEL_TCOUNT;
        end else if (word_addr == TCMP_WORD) begin
            sel = SEL_TCMP;
        end else if (word_addr == TSTAT_WORD) begin
            sel = SEL_TSTAT;
`endif
        end
    end

    // RAM contents survive reset; only the write enable is gated by it.
    always_ff @(posedge CLK) begin
        if (wr_en && sel == SEL_RAM) begin
            ram_q[ram_idx] <= WriteData;
        end
    end

    always_comb begin
        leds_d = leds_q;
        if (wr_en && sel == SEL_LED) begin
            leds_d = WriteData[7:0];
        end
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            leds_q <= 8'h00;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds = leds_q;

`ifdef TIMER_EN
    logic [31:0] tcount;
    logic [31:0] tcmp;
    logic        tflag;

    mmio_timer u_timer (
        .clk   (CLK),
        .rst_n (rst_n_int),
        .wr_en (wr_en),
        .sel   (sel),
        .wdata (WriteData),
        .count (tcount),
        .cmp   (tcmp),
        .flag  (tflag)
    );

    assign irq = tflag;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        ReadData = 32'h0000_0000;
        case (sel)
            SEL_RAM:    ReadData = ram_q[ram_idx];
            SEL_LED:    ReadData = {24'h00_0000, leds_q};
`ifdef TIMER_EN
            SEL_TCOUNT: ReadData = tcount;
            SEL_TCMP:   ReadData = tcmp;
            SEL_TSTAT:  ReadData = {31'h0, tflag};
`endif
            default:    ReadData = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_data_mem_bus.sv
// Directed bench for data_mem_bus: RAM, LED latch, unmapped space, reset,
// and the timer block when TIMER_EN is defined.
module tb_data_mem_bus;
    import mem_map_pkg::*;

    localparam logic [31:0] IO = 32'h0000_1000;

    logic        CLK       = 1'b0;
    logic        reset     = 1'b1;
    logic        MemWrite  = 1'b0;
    logic [31:0] ALUResult = IO;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic        irq;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 CLK = ~CLK;

    data_mem_bus #(.DEPTH_WORDS(64), .IO_BASE(IO)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .leds      (leds),
        .irq       (irq)
    );

    // Drive one bus cycle just after the edge, leaving time to settle before sampling.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        @(posedge CLK);
        #1;
        MemWrite  = we;
        ALUResult = addr;
        WriteData = data;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check_output("reset_leds", {24'h0, leds}, 32'h0);
        check_output("reset_irq", {31'h0, irq}, 32'h0);
        check_output("reset_led_read", ReadData, 32'h0);
        repeat (2) @(posedge CLK);
        #3 reset = 1'b1;
        repeat (3) apply_stimulus(1'b0, 32'h0, 32'h0);

        // RAM write/read, old-data on same-cycle read
        apply_stimulus(1'b1, 32'h10, 32'h1111_1111);
        apply_stimulus(1'b1, 32'h14, 32'h2222_2222);
        apply_stimulus(1'b1, 32'h00, 32'h0A0A_0A0A);
        apply_stimulus(1'b1, 32'h18, 32'h3333_3333);
        apply_stimulus(1'b1, 32'h10, 32'hDEAD_BEEF);
        check_output("ram_same_cycle_old", ReadData, 32'h1111_1111);
        apply_stimulus(1'b0, 32'h10, 32'h0);
        check_output("ram_read_back", ReadData, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 32'h13, 32'h0);
        check_output("ram_low_bits_ignored", ReadData, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 32'h14, 32'h0);
        check_output("ram_neighbour", ReadData, 32'h2222_2222);

        // LED latch
        apply_stimulus(1'b1, IO, 32'h0000_01A5);
        apply_stimulus(1'b0, IO, 32'h0);
        check_output("led_value", {24'h0, leds}, 32'h0000_00A5);
        check_output("led_read", ReadData, 32'h0000_00A5);
        apply_stimulus(1'b0, IO + 32'h3, 32'h0);
        check_output("led_read_low_bits", ReadData, 32'h0000_00A5);

        // Unmapped space and the first address past the RAM
        apply_stimulus(1'b1, 32'h2000, 32'hFFFF_FFFF);
        check_output("unmapped_2000_rd", ReadData, 32'h0);
        apply_stimulus(1'b1, 32'h100, 32'h1234_5678);
        check_output("unmapped_ram_end_rd", ReadData, 32'h0);
        apply_stimulus(1'b0, 32'h00, 32'h0);
        check_output("ram_no_alias", ReadData, 32'h0A0A_0A0A);
        check_output("led_unchanged", {24'h0, leds}, 32'h0000_00A5);
        apply_stimulus(1'b0, 32'h100, 32'h0);
        check_output("unmapped_ram_end_rd2", ReadData, 32'h0);

`ifndef TIMER_EN
        apply_stimulus(1'b1, IO + 32'h4, 32'h5);
        apply_stimulus(1'b0, IO + 32'h4, 32'h0);
        check_output("no_timer_tcount", ReadData, 32'h0);
        check_output("no_timer_irq", {31'h0, irq}, 32'h0);
        apply_stimulus(1'b1, IO + 32'h8, 32'h1);
        apply_stimulus(1'b0, IO + 32'h8, 32'h0);
        check_output("no_timer_tcmp", ReadData, 32'h0);
        apply_stimulus(1'b0, IO + 32'hC, 32'h0);
        check_output("no_timer_tstat", ReadData, 32'h0);
        check_output("no_timer_irq2", {31'h0, irq}, 32'h0);
`else
        // Match at count 5 raises irq one cycle later
        check_output("irq_idle", {31'h0, irq}, 32'h0);
        apply_stimulus(1'b1, IO + 32'h4, 32'h0);
        apply_stimulus(1'b1, IO + 32'h8, 32'h5);
        check_output("tcmp_old", ReadData, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1'b0, IO + 32'h4, 32'h0);
            check_output("tcount_step", ReadData, 32'(i));
            check_output("irq_before_match", {31'h0, irq}, 32'h0);
        end
        apply_stimulus(1'b0, IO + 32'hC, 32'h0);
        check_output("irq_after_match", {31'h0, irq}, 32'h1);
        check_output("tstat_set", ReadData, 32'h1);
        apply_stimulus(1'b0, IO + 32'h8, 32'h0);
        check_output("tcmp_read", ReadData, 32'h5);
        apply_stimulus(1'b1, IO + 32'hC, 32'h1);
        check_output("irq_during_clear", {31'h0, irq}, 32'h1);
        apply_stimulus(1'b0, IO + 32'hC, 32'h0);
        check_output("irq_cleared", {31'h0, irq}, 32'h0);
        check_output("tstat_cleared", ReadData, 32'h0);

        // Wrap and write-over-increment
        apply_stimulus(1'b1, IO + 32'h4, 32'hFFFF_FFFE);
        apply_stimulus(1'b0, IO + 32'h4, 32'h0);
        check_output("wrap_fffe", ReadData, 32'hFFFF_FFFE);
        apply_stimulus(1'b0, IO + 32'h4, 32'h0);
        check_output("wrap_ffff", ReadData, 32'hFFFF_FFFF);
        apply_stimulus(1'b0, IO + 32'h4, 32'h0);
        check_output("wrap_zero", ReadData, 32'h0);
        apply_stimulus(1'b1, IO + 32'h4, 32'h100);
        apply_stimulus(1'b0, IO + 32'h4, 32'h0);
        check_output("write_beats_inc", ReadData, 32'h100);

        // Clear in the same cycle as a new match: set wins
        apply_stimulus(1'b1, IO + 32'h4, 32'h5);
        apply_stimulus(1'b1, IO + 32'hC, 32'h1);
        check_output("tstat_pre_collide", ReadData, 32'h0);
        apply_stimulus(1'b0, IO + 32'hC, 32'h0);
        check_output("set_wins_irq", {31'h0, irq}, 32'h1);
        check_output("set_wins_tstat", ReadData, 32'h1);
        apply_stimulus(1'b1, IO + 32'hC, 32'h1);
        apply_stimulus(1'b0, IO + 32'hC, 32'h0);
        check_output("irq_cleared2", {31'h0, irq}, 32'h0);

        // TCMP = 0 disables matching even at count 0
        apply_stimulus(1'b1, IO + 32'h8, 32'h0);
        apply_stimulus(1'b1, IO + 32'h4, 32'h0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, IO + 32'h4, 32'h0);
            check_output("tcmp0_count", ReadData, 32'(i));
            check_output("tcmp0_no_irq", {31'h0, irq}, 32'h0);
        end
        apply_stimulus(1'b1, 32'h2000, 32'h5);
        apply_stimulus(1'b0, IO + 32'h8, 32'h0);
        check_output("tcmp_unmapped_safe", ReadData, 32'h0);
`endif

        // Asynchronous reset mid-run with a RAM write in flight
        @(posedge CLK);
        #1;
        MemWrite  = 1'b1;
        ALUResult = 32'h18;
        WriteData = 32'h0000_0055;
        #2 reset = 1'b0;
        #1;
        check_output("midrun_leds_cleared", {24'h0, leds}, 32'h0);
        check_output("midrun_irq", {31'h0, irq}, 32'h0);
        @(posedge CLK);
        #1;
        MemWrite  = 1'b0;
        ALUResult = IO;
        #1;
        check_output("midrun_led_read", ReadData, 32'h0);
        #2 reset = 1'b1;
        repeat (3) apply_stimulus(1'b0, 32'h18, 32'h0);
        check_output("inflight_write_dropped", ReadData, 32'h3333_3333);
        apply_stimulus(1'b0, IO, 32'h0);
        check_output("led_after_reset", ReadData, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
